uart_rx: RTL and testbench

//  UART receiver; the downstream counterpart of the TX stage. It consumes the serial line TXD drives.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame bit levels.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for an asynchronous input; flops reset to the idle-high level.
module rx_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling, valid/ack word delivery
// with framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int OVS  = 16
) (
  input  logic            RXC,
  input  logic            R,
  input  logic            RXD,
  input  logic            RX_ACK,
  output logic [SIZE-1:0] RXDATA,
  output logic            RX_VALID,
  output logic            RX_FERR,
  output logic            RX_OVR,
  output logic            RX_BUSY
);

  localparam int CTR_W  = $clog2(OVS);
  localparam int BITN_W = $clog2(SIZE + 1);

  localparam logic [CTR_W-1:0]  HALF_M1  = CTR_W'(OVS / 2 - 1);
  localparam logic [CTR_W-1:0]  FULL_M1  = CTR_W'(OVS - 1);
  localparam logic [BITN_W-1:0] LAST_BIT = BITN_W'(SIZE - 1);

  logic              rxs;
  logic              rxs_d_q;
  rx_state_t         state_q;
  logic [CTR_W-1:0]  ctr_q;
  logic [BITN_W-1:0] bitn_q;
  logic [SIZE-1:0]   shift_q;
  logic [SIZE-1:0]   shift_d;
  logic              stop_q;
  logic              deliver_q;
  logic [SIZE-1:0]   rxdata_q;
  logic              valid_q;
  logic              ferr_q;
  logic              ovr_q;
  logic              busy_q;

  rx_sync #(.N(2)) u_sync (
    .clk_i (RXC),
    .rst_i (R),
    .d_i   (RXD),
    .q_o   (rxs)
  );

  // LSB-first: each new sample enters at the MSB and the word drifts down.
  always_comb begin
    shift_d          = shift_q >> 1;
    shift_d[SIZE-1]  = rxs;
  end

  always_ff @(posedge RXC or posedge R) begin
    if (R) begin
      rxs_d_q   <= 1'b1;
      state_q   <= IDLE;
      ctr_q     <= '0;
      bitn_q    <= '0;
      shift_q   <= '0;
      stop_q    <= 1'b0;
      deliver_q <= 1'b0;
      rxdata_q  <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rxs_d_q   <= rxs;
      deliver_q <= 1'b0;

      // Delivery precedes the FSM so a start edge in the same cycle keeps BUSY set.
      if (deliver_q) begin
        busy_q <= 1'b0;
        if (!valid_q || RX_ACK) begin
          rxdata_q <= shift_q;
          ferr_q   <= (stop_q != STOP_BIT);
          valid_q  <= 1'b1;
          ovr_q    <= 1'b0;
        end else begin
          ovr_q    <= 1'b1;
        end
      end else if (RX_ACK && valid_q) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rxs_d_q && !rxs) begin
            state_q <= START;
            ctr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (ctr_q == HALF_M1) begin
            ctr_q  <= '0;
            bitn_q <= '0;
            if (rxs == START_BIT) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            ctr_q <= ctr_q + CTR_W'(1);
          end
        end
        DATA: begin
          if (ctr_q == FULL_M1) begin
            ctr_q   <= '0;
            shift_q <= shift_d;
            bitn_q  <= bitn_q + BITN_W'(1);
            if (bitn_q == LAST_BIT) begin
              state_q <= STOP;
            end
          end else begin
            ctr_q <= ctr_q + CTR_W'(1);
          end
        end
        STOP: begin
          if (ctr_q == FULL_M1) begin
            ctr_q     <= '0;
            stop_q    <= rxs;
            deliver_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            ctr_q <= ctr_q + CTR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RXDATA   = rxdata_q;
  assign RX_VALID = valid_q;
  assign RX_FERR  = ferr_q;
  assign RX_OVR   = ovr_q;
  assign RX_BUSY  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised by the bench, expected words queued,
// and a monitor compares each delivered word.
module tb_uart_rx;

  logic       RXC = 1'b0;
  logic       R;
  logic       RXD;
  logic       RX_ACK;
  logic [7:0] RXDATA;
  logic       RX_VALID;
  logic       RX_FERR;
  logic       RX_OVR;
  logic       RX_BUSY;

  logic stim_ack = 1'b0;
  logic mon_ack  = 1'b0;
  logic auto_ack = 1'b1;
  logic prev_v   = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;

  assign RX_ACK = stim_ack | mon_ack;

  uart_rx #(.SIZE(8), .OVS(16)) dut (
    .RXC      (RXC),
    .R        (R),
    .RXD      (RXD),
    .RX_ACK   (RX_ACK),
    .RXDATA   (RXDATA),
    .RX_VALID (RX_VALID),
    .RX_FERR  (RX_FERR),
    .RX_OVR   (RX_OVR),
    .RX_BUSY  (RX_BUSY)
  );

  always #5 RXC = ~RXC;

  always @(posedge RXC) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising RX_VALID must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge RXC);
      mon_ack = 1'b0;
      if (RX_VALID && !prev_v) begin
        rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", RXDATA);
        end else begin
          e = exp_q.pop_front();
          chk("rxdata", {24'd0, RXDATA}, {24'd0, e.data});
          chk("ferr", {31'd0, RX_FERR}, {31'd0, e.ferr});
          chk("ovr_on_delivery", {31'd0, RX_OVR}, 32'd0);
        end
        if (auto_ack) mon_ack = 1'b1;
      end
      prev_v = RX_VALID;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge RXC);
    #2;
  endtask

  task automatic send_bit(input logic b);
    RXD = b;
    wait_cyc(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic chk_busy);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (chk_busy && i == 3) chk("busy_mid_frame", {31'd0, RX_BUSY}, 32'd1);
    end
    send_bit(stop);
  endtask

  task automatic expect_word(input logic [7:0] d, input logic ferr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  initial begin
    int busy_cnt;
    int lat;
    int gap;
    logic [7:0] d;
    logic stop;
    logic [7:0] loop_words [3];

    R   = 1'b1;
    RXD = 1'b1;
    wait_cyc(3);
    chk("reset_valid", {31'd0, RX_VALID}, 32'd0);
    chk("reset_busy", {31'd0, RX_BUSY}, 32'd0);
    chk("reset_ferr_ovr", {30'd0, RX_FERR, RX_OVR}, 32'd0);
    chk("reset_rxdata", {24'd0, RXDATA}, 32'd0);
    R = 1'b0;
    wait_cyc(5);

    // Frame 0xA5 with latency and busy checks
    expect_word(8'hA5, 1'b0);
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_cyc(2);
    chk("busy_after_frame", {31'd0, RX_BUSY}, 32'd0);
    lat = rise_cyc - fall_cyc;
    chk("latency_155pm1", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);

    // Short low pulse: rejected as a glitch
    RXD = 1'b0;
    wait_cyc(4);
    RXD = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      wait_cyc(1);
      if (RX_BUSY) busy_cnt++;
    end
    chk("glitch_busy_brief", {31'd0, (busy_cnt >= 5 && busy_cnt <= 10)}, 32'd1);
    chk("glitch_no_valid", {31'd0, RX_VALID}, 32'd0);

    // Framing error then line held low
    expect_word(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      wait_cyc(1);
      if (RX_BUSY) busy_cnt++;
    end
    chk("break_no_retrigger", busy_cnt, 32'd0);
    RXD = 1'b1;
    wait_cyc(20);

    // Overrun: two frames, no acknowledge
    auto_ack = 1'b0;
    expect_word(8'h11, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_cyc(4);
    chk("ovr_valid", {31'd0, RX_VALID}, 32'd1);
    chk("ovr_rxdata_kept", {24'd0, RXDATA}, 32'h11);
    chk("ovr_flag", {31'd0, RX_OVR}, 32'd1);
    stim_ack = 1'b1;
    wait_cyc(1);
    stim_ack = 1'b0;
    chk("ack_clears", {29'd0, RX_VALID, RX_OVR, RX_FERR}, 32'd0);
    auto_ack = 1'b1;
    wait_cyc(4);

    // Reset in the middle of data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_cyc(8);
    R = 1'b1;
    #1;
    chk("reset_midframe_outs", {28'd0, RX_VALID, RX_BUSY, RX_FERR, RX_OVR}, 32'd0);
    wait_cyc(3);
    R = 1'b0;
    wait_cyc(30);
    chk("after_reset_outs", {28'd0, RX_VALID, RX_BUSY, RX_FERR, RX_OVR}, 32'd0);
    chk("after_reset_rxdata", {24'd0, RXDATA}, 32'd0);
    expect_word(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_cyc(4);

    // Back-to-back frames as a TX stage would emit them
    loop_words[0] = 8'h00;
    loop_words[1] = 8'hFF;
    loop_words[2] = 8'h81;
    for (int i = 0; i < 3; i++) begin
      expect_word(loop_words[i], 1'b0);
      send_frame(loop_words[i], 1'b1, 1'b0);
    end
    wait_cyc(4);

    // Randomised frames, gaps, bad stop bits and glitches
    for (int n = 0; n < 25; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 20);
      expect_word(d, ~stop);
      send_frame(d, stop, 1'b0);
      RXD = 1'b1;
      if (!stop && gap < 4) gap = 4;
      if (gap > 0) wait_cyc(gap);
      if ($urandom_range(0, 3) == 0) begin
        RXD = 1'b0;
        wait_cyc($urandom_range(1, 5));
        RXD = 1'b1;
        wait_cyc(20);
      end
    end
    wait_cyc(20);
    chk("all_words_delivered", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
